multiplier_seq: RTL and testbench
=================================

Name: multiplier_seq

Overview:
- Parametrised, iterative shift-add multiplier that retires STEP multiplier bits per clock.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Uses a valid/ready handshake on both sides and holds one operation in flight.
- Serves as the area-efficient multiplier for the datapath's multiply unit and replaces the purely combinational array form.

Parameters:
- WIDTH, 32: operand width in bits. Must be ≥2 and a multiple of STEP.
- STEP, 1: multiplier bits consumed per cycle. Legal values are 1, 2, 4. Elaboration fails with $error otherwise.
- N (localparam), WIDTH/STEP: number of iteration cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept an operation
- in_signed  input  1  1 = treat in1/in2 as two's complement; 0 = unsigned
- in1  input  WIDTH  multiplicand
- in2  input  WIDTH  multiplier
- out_valid  output  1  product available
- out_ready  input  1  consumer accepts the product
- out  output  2*WIDTH  product, registered

Behaviour:
- Interface is fixed: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state:
  - state=IDLE, in_ready=1, out_valid=0, out=0.
  - Counter and accumulator are cleared.
  - rst dominates every other input on the same edge.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready:
    - Latch the operand magnitudes. If in_signed, |x| is computed in WIDTH bits unsigned; -2^(WIDTH-1) becomes 2^(WIDTH-1), with no overflow.
    - Latch neg = in_signed & (in1[MSB]^in2[MSB]).
    - Clear the accumulator, load count=N, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: acc += (mcand_mag * mplier_mag[STEP-1:0]) << (STEP*(N-count)), implemented as an equivalent shift-right accumulate. Then mplier_mag >>= STEP and count--.
  - Accumulator is 2*WIDTH+STEP bits internally; the final result is truncated to 2*WIDTH bits, which is exact.
  - On the cycle count reaches 1, that edge writes out = neg ? -acc_final : acc_final (2*WIDTH two's complement), sets out_valid=1, and goes to DONE.
- DONE:
  - out_valid=1; out and out_valid are stable while out_ready=0.
  - in_ready=0: there is no overlap with the next operation.
  - On an edge with out_ready=1, clear out_valid and go to IDLE. out keeps its last value and is don't-care while out_valid=0.
- Latency: accept on edge k gives out_valid=1 after edge k+N. Best-case throughput is one operation per N+2 cycles (accept, N iterations, drain).
- Zero operand: no early termination. Latency is always N.
- Mode-independent corner cases: unsigned max*max is exact; signed min*min = +2^(2*WIDTH-2) is exact.
- in_valid while not in IDLE is ignored. Operands are not sampled.
- rst during BUSY or DONE aborts the operation: out_valid=0 on the next cycle and the result is discarded.
- Counter width is $clog2(N+1). No wrap occurs; count never decrements below 1 in BUSY.

Test Plan:
- WIDTH=32, STEP=1, unsigned: 3*5 -> out=64'd15, out_valid exactly 32 cycles after accept. in_ready low during those 32 cycles and the DONE cycle(s).
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001. Signed same operands (-1*-1) -> 0x0000000000000001.
- Signed: -7*3 -> 0xFFFFFFFFFFFFFFEB. 0x80000000*0x80000000 signed -> 0x4000000000000000; unsigned -> 0x4000000000000000. 0x80000000*1 signed -> 0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out and out_valid unchanged, in_ready=0, and a new in_valid pulse is not accepted. Release -> IDLE next cycle; the next operation is accepted.
- Reset mid-op: assert rst at iteration 10 of 32 -> next cycle in_ready=1, out_valid=0, out=0. A following 2*2 yields 4 with full 32-cycle latency.
- Parameter sweep WIDTH∈{8,16,32}, STEP∈{1,2,4}, 1000 random ops per config, both modes, random out_ready stalls -> matches a reference model and latency==WIDTH/STEP every time.

Source files
------------

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier: retires STEP multiplier bits per clock,
// unsigned or two's-complement per operation, valid/ready on both sides.
module multiplier_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * WIDTH + STEP;

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4) || WIDTH < 2 || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("multiplier_seq: STEP must be 1, 2 or 4 and divide WIDTH (WIDTH >= 2)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      mplier;
  logic                  neg;
  logic [CW-1:0]         count;
  logic [AW-1:0]         acc;

  logic [WIDTH-1:0]      mag1;
  logic [WIDTH-1:0]      mag2;
  logic [WIDTH+STEP-1:0] partial;
  logic [AW-1:0]         sum;
  logic [AW-1:0]         acc_shifted;
  logic [2*WIDTH-1:0]    product;

  // Magnitudes in WIDTH unsigned bits: the most negative value maps onto itself,
  // which read unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    mag1 = (in_signed && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
    mag2 = (in_signed && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
  end

  // Partial product enters at bit WIDTH and the whole accumulator shifts right
  // by STEP, so after N cycles each partial lands at its proper weight.
  always_comb begin
    partial     = {{STEP{1'b0}}, mcand} * {{WIDTH{1'b0}}, mplier[STEP-1:0]};
    sum         = acc + {partial, {WIDTH{1'b0}}};
    acc_shifted = sum >> STEP;
    product     = acc_shifted[2*WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (count == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      count  <= '0;
      acc    <= '0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= mag1;
            mplier <= mag2;
            neg    <= in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            acc    <= '0;
            count  <= CW'(N);
          end
        end
        BUSY: begin
          acc    <= acc_shifted;
          mplier <= mplier >> STEP;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            out <= neg ? (~product + 1'b1) : product;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed-vector and corner-case bench for multiplier_seq (WIDTH=32, STEP=1).
module tb_multiplier_seq;

  localparam int W = 32;
  localparam int S = 1;
  localparam int N = W / S;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplier_seq #(.WIDTH(W), .STEP(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one operation, wait for the product, hold out_ready low for `stall`
  // cycles (poking in_valid once, which must be ignored), then drain.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int stall, output logic [2*W-1:0] res, output int lat);
    int busy_ready = 0;
    @(negedge clk);
    in1 = a; in2 = b; in_signed = s; in_valid = 1'b1;
    check("accept_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = ~a; in2 = ~b;
    lat = 0;
    while (!out_valid && lat < 4 * N) begin
      if (in_ready) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
    check("busy_in_ready_low", 64'(busy_ready), 64'd0);
    check("done_in_ready_low", 64'(in_ready), 64'd0);
    res = out;
    for (int i = 0; i < stall; i++) begin
      in_valid = (i == 1);
      in1 = 32'd9; in2 = 32'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_stable", out, res);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);
    $display("op a=%h b=%h signed=%0d stall=%0d -> out=%h latency=%0d", a, b, s, stall, res, lat);
  endtask

  initial begin
    logic [2*W-1:0] res;
    logic [2*W-1:0] exp;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;
    int             lat;

    vecs[0]  = '{32'd3,         32'd5,         1'b0, 64'd15};
    vecs[1]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE00000001};
    vecs[2]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 64'h0000000000000001};
    vecs[3]  = '{32'hFFFFFFF9,  32'd3,         1'b1, 64'hFFFFFFFFFFFFFFEB};
    vecs[4]  = '{32'h80000000,  32'h80000000,  1'b1, 64'h4000000000000000};
    vecs[5]  = '{32'h80000000,  32'h80000000,  1'b0, 64'h4000000000000000};
    vecs[6]  = '{32'h80000000,  32'd1,         1'b1, 64'hFFFFFFFF80000000};
    vecs[7]  = '{32'd0,         32'd12345,     1'b1, 64'd0};
    vecs[8]  = '{32'h7FFFFFFF,  32'h7FFFFFFF,  1'b1, 64'h3FFFFFFF00000001};
    vecs[9]  = '{32'hFFFFFFFF,  32'd5,         1'b0, 64'h00000004FFFFFFFB};
    vecs[10] = '{32'hFFFFFFFF,  32'd5,         1'b1, 64'hFFFFFFFFFFFFFFFB};
    vecs[11] = '{32'h00010000,  32'h00010000,  1'b1, 64'h0000000100000000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0;
    in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out", out, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, res, lat);
      check($sformatf("vec%0d_out", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
    end

    // Backpressure for 5 cycles with an ignored in_valid pulse, then a fresh op.
    run_op(32'd1000, 32'd1000, 1'b0, 5, res, lat);
    check("bp_out", res, 64'd1000000);
    run_op(32'hFFFFFFFE, 32'd7, 1'b1, 0, res, lat);
    check("after_bp_out", res, 64'hFFFFFFFFFFFFFFF2);
    check("after_bp_latency", 64'(lat), 64'(N));

    // Reset at iteration 10 of an operation aborts it.
    @(negedge clk);
    in1 = 32'd100; in2 = 32'd200; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", out, 64'd0);
    $display("reset asserted mid-operation");
    run_op(32'd2, 32'd2, 1'b0, 0, res, lat);
    check("postrst_out", res, 64'd4);
    check("postrst_latency", 64'(lat), 64'(N));

    // Random operations against a 64-bit reference product.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (rs) exp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
      else    exp = {32'd0, ra} * {32'd0, rb};
      run_op(ra, rb, rs, int'($urandom_range(0, 3)), res, lat);
      check($sformatf("rand%0d_out", i), res, exp);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(N));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
